// File: rtl/mux_n_arb.sv
// N-input arbitrated multiplexer with a one-entry registered output and valid/ready handshakes.
// Define MUX_ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module mux_n_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0][WIDTH-1:0] din;
  logic                    load;
  logic                    gnt_vld;
  logic [SEL_W-1:0]        gnt_idx;

  assign din  = in_data;
  assign load = !out_valid || out_ready;

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0] last;

  // Search starts one past the last winner so every requester is served within N grants.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last <= SEL_W'(N - 1);
    else if (load && gnt_vld) last <= gnt_idx;
  end
`else
  // Descending scan so the lowest asserted index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(k);
      end
    end
  end
`endif

  always_comb begin
    in_ready = '0;
    if (!rst && load && gnt_vld) in_ready = N'(1) << gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= din[gnt_idx];
        out_sel  <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_arb.sv
// Self-checking bench for mux_n_arb: directed scenarios plus random traffic against a behavioural model.
module tb_mux_n_arb;
  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  int errors = 0;
  int checks = 0;

  // Reference state: what the output register should hold, and the last granted channel.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_last;

  mux_n_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_last  = N - 1;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".data"},  64'(out_data),  64'(m_data));
    chk({tag, ".sel"},   64'(out_sel),   64'(m_sel));
  endtask

  // One clock: drive inputs away from the edge, check ready, clock, check the output register.
  task automatic step(input logic [N-1:0] v, input logic r, input logic [N*WIDTH-1:0] d, input string tag);
    bit load;
    int g, c;
    logic [N-1:0] exp_rdy;
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    #1;
    load = !m_valid || r;
    g = -1;
    if (load) begin
      for (int k = 1; k <= N; k++) begin
`ifdef MUX_ARB_RR_EN
        c = (m_last + k) % N;
`else
        c = k - 1;
`endif
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = d[g*WIDTH +: WIDTH];
        m_sel  = g;
        m_last = g;
      end
    end
    #1;
    chk_out(tag);
  endtask

  function automatic logic [N*WIDTH-1:0] rnd_data();
    logic [N*WIDTH-1:0] d;
    for (int i = 0; i < N; i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  initial begin
    logic [N*WIDTH-1:0] d;

    // Reset with every channel requesting: nothing may be granted.
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = rnd_data();
    model_reset();
    #3;
    chk("reset.in_ready", 64'(in_ready), 64'd0);
    chk_out("reset");
    @(negedge clk); rst = 1'b0;
    step(4'b1111, 1'b1, rnd_data(), "first_grant");

    // Channel 2 streams A0..A3 back-to-back.
    for (int i = 0; i < 4; i++) begin
      d = rnd_data();
      d[2*WIDTH +: WIDTH] = 32'hA0 + i;
      step(4'b0100, 1'b1, d, "stream2");
    end
    step(4'b0000, 1'b1, rnd_data(), "drain");

    // Back-pressure with all inputs valid, then release.
    step(4'b1111, 1'b0, rnd_data(), "bp_load");
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, rnd_data(), "bp_hold");
    step(4'b1111, 1'b1, rnd_data(), "bp_release");

    // All channels, then channels 1 and 3 only.
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, rnd_data(), "all4");
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, rnd_data(), "ch13");
    step(4'b1000, 1'b1, rnd_data(), "ch3only");

    // Reset while holding a stalled word.
    d = rnd_data();
    d[0 +: WIDTH] = 32'hDEADBEEF;
    step(4'b0001, 1'b0, d, "hold_dead");
    step(4'b0000, 1'b0, rnd_data(), "hold_dead2");
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    chk_out("midrst");
    @(negedge clk); rst = 1'b0;
    step(4'b1111, 1'b1, rnd_data(), "after_rst");

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(4'($urandom), 1'($urandom_range(0, 3) != 0), rnd_data(), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
